dwc_compare_core: RTL

- Duplication-with-comparison datapath feeding the myDWC AXI4-Lite register slave.
- Accepts result words from two redundant cores (lane A, lane B) over valid/ready and absorbs lane skew in per-lane FIFOs.
- Compares words pairwise and forwards agreed words downstream.
- Counts compares and mismatches, captures the last mismatching pair, raises sticky error flags, and exposes all of these as register-slave inputs.

---
 rtl/dwc_pkg.sv | 14 +
 rtl/dwc_lane_fifo.sv | 35 +++
 rtl/dwc_compare_core.sv | 107 ++++++++++
 3 files changed

// File: rtl/dwc_pkg.sv
// dwc_pkg: shared state encoding, default widths and counter saturation helper for dwc_compare_core
package dwc_pkg;
  localparam int DATA_W_DEF      = 32;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int TIMEOUT_CYC_DEF = 256;
  localparam int CNT_W_DEF       = 16;
  typedef enum logic [1:0] {RUN = 2'd0, LAG = 2'd1, FAULT = 2'd2} state_t;
  // w must be below 64; the counter sticks at its all-ones value
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (v == m) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/dwc_lane_fifo.sv
// dwc_lane_fifo: per-lane skew buffer, synchronous FIFO with flush and async active-high reset
module dwc_lane_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wp[AW-1:0]] <= din;
  assign dout  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

// File: rtl/dwc_compare_core.sv
// dwc_compare_core: duplication-with-comparison datapath; pairs lane words, forwards agreed ones, tracks faults.
// Optional: define DWC_HALT_ON_MISMATCH_EN to force FAULT after any mismatching compare.
module dwc_compare_core import dwc_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              clr,
  output logic              err_mismatch,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  cmp_cnt,
  output logic [CNT_W-1:0]  mis_cnt,
  output logic [DATA_W-1:0] last_a,
  output logic [DATA_W-1:0] last_b,
  output logic [1:0]        state_o
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t            state, state_nx;
  logic [TW-1:0]     timer, timer_nx;
  logic              tmo, rdy_en, pop, match, mis, flush;
  logic              a_full, a_empty, b_full, b_empty;
  logic [DATA_W-1:0] a_head, b_head;
  assign a_ready = rdy_en && !a_full && state != FAULT;
  assign b_ready = rdy_en && !b_full && state != FAULT;
  assign pop     = !a_empty && !b_empty && (!out_valid || out_ready) && state != FAULT;
  assign match   = a_head == b_head;
  assign mis     = pop && !match;
  assign flush   = clr && state == FAULT;
  assign state_o = state;
  dwc_lane_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk(ACLK), .rst(ARESET), .flush(flush), .push(a_valid && a_ready), .pop(pop),
    .din(a_data), .dout(a_head), .full(a_full), .empty(a_empty));
  dwc_lane_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk(ACLK), .rst(ARESET), .flush(flush), .push(b_valid && b_ready), .pop(pop),
    .din(b_data), .dout(b_head), .full(b_full), .empty(b_empty));
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    tmo      = 1'b0;
    if (state == RUN) begin
      if (a_empty ^ b_empty) begin
        state_nx = LAG;
        timer_nx = '0;
      end
    end else if (state == LAG) begin
      if (!(a_empty ^ b_empty)) state_nx = RUN;
      else if (timer == TW'(TIMEOUT_CYC - 1)) begin
        state_nx = FAULT;
        tmo      = 1'b1;
      end else timer_nx = timer + 1'b1;
    end else if (clr) state_nx = RUN;
`ifdef DWC_HALT_ON_MISMATCH_EN
    if (mis && !clr) state_nx = FAULT;
`endif
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state        <= RUN;
      timer        <= '0;
      rdy_en       <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      cmp_cnt      <= '0;
      mis_cnt      <= '0;
      err_mismatch <= 1'b0;
      err_timeout  <= 1'b0;
      last_a       <= '0;
      last_b       <= '0;
    end else begin
      state  <= state_nx;
      timer  <= timer_nx;
      rdy_en <= 1'b1;
      if (pop && match) begin
        out_valid <= 1'b1;
        out_data  <= a_head;
      end else if (out_ready) out_valid <= 1'b0;
      if (clr) begin
        cmp_cnt      <= '0;
        mis_cnt      <= '0;
        err_mismatch <= 1'b0;
        err_timeout  <= 1'b0;
        last_a       <= '0;
        last_b       <= '0;
      end else begin
        if (pop) cmp_cnt <= CNT_W'(sat_inc(64'(cmp_cnt), CNT_W));
        if (mis) begin
          mis_cnt      <= CNT_W'(sat_inc(64'(mis_cnt), CNT_W));
          last_a       <= a_head;
          last_b       <= b_head;
          err_mismatch <= 1'b1;
        end
        if (tmo) err_timeout <= 1'b1;
      end
    end
endmodule
